// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decoder with multi-cycle MUL/DIV hold
// Accepts {ALUOp, Opcode} on a valid/ready handshake and presents ALU_Cnt one cycle later.
module alu_ctrl_seq #(
  parameter int ALUOP_W    = 2,
  parameter int OPCODE_W   = 4,
  parameter int CNT_W      = 4,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  ALUOp,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                flush,
  output logic [CNT_W-1:0]    ALU_Cnt,
  output logic                out_valid,
  output logic                multi_busy,
  output logic                multi_done,
  output logic                illegal
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_MULTI} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d;
  logic             ill_q, ill_d;

  logic [CNT_W-1:0] dec_code;
  logic             dec_ill, dec_mul, dec_div;
  logic [3:0]       op_lo;
  logic             accept;

  assign op_lo = Opcode[3:0];

  always_comb begin
    dec_code = '0;
    dec_ill  = 1'b0;
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    if (ALUOp == ALUOP_W'(2)) begin
      dec_code = '0;
    end else if (ALUOp == ALUOP_W'(1)) begin
      dec_code = CNT_W'(1);
    end else if ((ALUOp == '0) && ((Opcode >> 4) == '0) &&
                 (op_lo >= 4'd2) && (op_lo <= 4'd11)) begin
      // Legal R-type opcodes 2..11 map linearly onto codes 0..9
      dec_code = CNT_W'(op_lo - 4'd2);
      dec_mul  = (op_lo == 4'd10);
      dec_div  = (op_lo == 4'd11);
    end else begin
      dec_ill  = 1'b1;
    end
  end

  assign in_ready = ~flush & ((state_q != S_MULTI) | (cnt_q == '0));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_cnt_d = alu_cnt_q;
    ill_d     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else if (accept) begin
      alu_cnt_d = dec_code;
      ill_d     = dec_ill;
      if (dec_mul) begin
        state_d = S_MULTI;
        cnt_d   = CW'(MUL_CYCLES - 1);
      end else if (dec_div) begin
        state_d = S_MULTI;
        cnt_d   = CW'(DIV_CYCLES - 1);
      end else begin
        state_d = S_SINGLE;
      end
    end else begin
      case (state_q)
        S_SINGLE: state_d = S_IDLE;
        S_MULTI: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      alu_cnt_q <= '0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_cnt_q <= alu_cnt_d;
      ill_q     <= ill_d;
    end
  end

  // ALU_Cnt deliberately retains its value in IDLE; consumers qualify with out_valid
  assign ALU_Cnt    = alu_cnt_q;
  assign out_valid  = (state_q != S_IDLE);
  assign multi_busy = (state_q == S_MULTI);
  assign multi_done = (state_q == S_MULTI) && (cnt_q == '0);
  assign illegal    = ill_q;

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised, registered successor to the combinational ALU control decoder. It accepts {ALUOp, Opcode} through a valid/ready handshake and produces a registered ALU_Cnt one cycle later. It adds two multi-cycle opcodes (MUL, DIV), holding ALU_Cnt stable for a programmable number of cycles while back-pressuring decode. It also adds illegal-encoding flagging and a pipeline flush. It sits between the main control unit and the ALU datapath of the RISC core.

Parameters:
ALUOP_W, 2, width of ALUOp input
OPCODE_W, 4, width of Opcode input (minimum 4)
CNT_W, 4, width of ALU_Cnt output (minimum 4, so that codes 8 and 9 are encodable)
MUL_CYCLES, 3, cycles ALU_Cnt is held for MUL (must be 2 or more)
DIV_CYCLES, 8, cycles ALU_Cnt is held for DIV (must be 2 or more)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode request valid
in_ready  out  1  block can accept request this cycle
ALUOp  in  ALUOP_W  operation class from main control
Opcode  in  OPCODE_W  instruction opcode
flush  in  1  synchronous abort of current/pending operation
ALU_Cnt  out  CNT_W  registered ALU control code
out_valid  out  1  ALU_Cnt is valid this cycle
multi_busy  out  1  a multi-cycle op is in progress
multi_done  out  1  pulse on the last cycle of a multi-cycle op
illegal  out  1  pulse: the presented encoding was undefined

Behaviour:
- Reset (async, rst_n=0): ALU_Cnt=0, out_valid=0, multi_busy=0, multi_done=0, illegal=0, state=IDLE, counter=0. Reset takes effect immediately, including mid-operation.
- Accept condition: in_valid && in_ready at a rising edge. Results are registered at that edge, so latency is 1 cycle.
- Decode for ALUOp=10: ALU_Cnt=0.
- Decode for ALUOp=01: ALU_Cnt=1.
- Decode for ALUOp=00, by Opcode: 0010→0, 0011→1, 0100→2, 0101→3, 0110→4, 0111→5, 1000→6, 1001→7, 1010→8 (MUL, multi-cycle), 1011→9 (DIV, multi-cycle).
- Any other ALUOp=00 opcode, or ALUOp=11: ALU_Cnt=0, illegal=1, treated as a single-cycle op.
- Opcode bits above bit 3 must be zero for a legal decode; otherwise the request is illegal.
- ALU_Cnt is zero-extended to CNT_W.
- States: IDLE, SINGLE, MULTI.
  - IDLE: out_valid=0. On accept, go to SINGLE, or to MULTI for codes 8/9.
  - SINGLE: out_valid=1 for exactly this cycle. On accept, reload (back-to-back issue is supported); otherwise go to IDLE.
  - MULTI: counter is loaded with N-1 (N=MUL_CYCLES or DIV_CYCLES) and decrements each cycle. ALU_Cnt, out_valid=1 and multi_busy=1 are held for N cycles. multi_done=1 when counter==0 (the final cycle).
- in_ready = ~flush & (state!=MULTI | counter==0). A new request can therefore be accepted on the final MULTI cycle and issues with no bubble.
- illegal and multi_done are single-cycle pulses, coincident with out_valid for the affected op.
- ALU_Cnt retains its last value in IDLE; downstream logic must qualify it with out_valid.
- flush=1 at an edge: next state is IDLE, out_valid=0, multi_busy=0, and multi_done is suppressed. No request is accepted in that cycle; flush has priority over in_valid.
- Simultaneous in_valid and in_ready low: the request is not consumed, and the requester must hold it stable.
- Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)). There is no wrap-around: the counter saturates at 0 and reloads only on accept.

Test Plan:
- Reset: assert rst_n=0 mid-MUL (cycle 2) → same cycle ALU_Cnt=0, out_valid=0, multi_busy=0; after release, in_ready=1 and state=IDLE.
- Single op: ALUOp=00, Opcode=0110 accepted at edge t → at t+1 ALU_Cnt=4, out_valid=1, illegal=0; at t+2 out_valid=0 with ALU_Cnt still 4.
- Back-to-back: Opcode 0010, 1001, then ALUOp=10 on consecutive cycles → ALU_Cnt sequence 0, 7, 0 with out_valid continuously 1 for 3 cycles.
- MUL, MUL_CYCLES=3: accept 1010 with SUB (0011) held on in_valid → ALU_Cnt=8 for 3 cycles, in_ready=0 for the first 2, multi_done on the 3rd; SUB accepted on the 3rd cycle, so the next cycle has ALU_Cnt=1.
- Illegal: ALUOp=00, Opcode=1111 → ALU_Cnt=0, out_valid=1, illegal=1 for one cycle; repeat with ALUOp=11, Opcode=0100 → same response.
- Flush: DIV accepted, flush=1 on its 2nd busy cycle while in_valid=1 → next cycle out_valid=0, multi_busy=0, no multi_done, request not consumed, in_ready=1 once flush drops.
